mac_seq_ctrl: RTL
=================

Name: mac_seq_ctrl

Overview:
- Parametrised sequencer for the neuron MAC datapath.
- On each accepted start it steps the weight/pixel select indices and walks a one-hot lane-enable vector across the accumulator lanes.
- After a configurable pipeline-drain delay it pulses ENX and then Output_Valid.
- Adds stall, a busy/start-drop handshake and a selectable restart policy; sits between the input loader and the MAC/accumulator array.

Parameters:
- NUM_TAPS, 28: weight/pixel steps per pass (select range 0..NUM_TAPS-1).
- SEL_W, 5: select width; must satisfy 2**SEL_W >= NUM_TAPS.
- NUM_EN, 28: one-hot enable lanes (ENX_Int width).
- EN_START, 24: step index at which the enable walk begins.
- PIPE_LAT, 13: steps from walk/tap end to ENX; must be >= 1.
- RESTART_ON_START, 1: 1 = Input_Valid while busy restarts the pass; 0 = ignored and flagged.

Ports:
- clk  in  1  clock.
- GlobalReset  in  1  asynchronous, active-high reset.
- Input_Valid  in  1  start request, sampled on rising clk.
- Stall  in  1  freezes stepping in RUN/DRAIN.
- WeightX_Select  out  SEL_W  weight index.
- PixelX_Select  out  SEL_W  pixel index (always equal to WeightX_Select).
- ENX_Int  out  NUM_EN  one-hot lane enable.
- ENX  out  1  one-cycle accumulate-commit pulse.
- Output_Valid  out  1  one-cycle result-valid pulse.
- Busy  out  1  pass in progress.
- Start_Drop  out  1  one-cycle pulse when a start is ignored.

Behaviour:
- Reset (async, any state): state IDLE, step counter t=0, selects 0, ENX_Int = 1 (bit0), ENX/Output_Valid/Busy/Start_Drop = 0. All outputs are registered.
- Internal step counter t counts advanced cycles since accept; its width is local, sized to hold T_FIRE+1.
- Derived constants: T_WALK = EN_START+NUM_EN-1; T_END = max(NUM_TAPS-1, T_WALK); T_FIRE = T_END+PIPE_LAT.
- States are IDLE, RUN, DRAIN, FIRE, DONE.
- IDLE: Input_Valid=1 at an edge -> RUN, t=0, selects 0, ENX_Int=1, Busy=1 in the following cycle.
- RUN (t <= T_END) and DRAIN (T_END < t < T_FIRE): each cycle with Stall=0, t increments by 1. Stall=1 holds t and all outputs.
- Select = min(t, NUM_TAPS-1); saturates, never wraps.
- ENX_Int = 1 << clamp(t-EN_START, 0, NUM_EN-1): one shift per advanced step from t=EN_START+1, then holds at the MSB lane. Exactly one bit is set at all times.
- RUN -> DRAIN when t advances past T_END; DRAIN -> FIRE when t reaches T_FIRE.
- FIRE: ENX=1 for exactly one cycle, then DONE. Stall is ignored in FIRE and DONE, so pulses are never stretched.
- DONE: Output_Valid=1 for exactly one cycle, Busy still 1.
  - Next state IDLE, with all outputs back to their reset values.
  - If Input_Valid=1 in DONE: go straight to RUN with t=0 (back-to-back passes, no idle bubble).
- Input_Valid=1 in RUN/DRAIN/FIRE:
  - RESTART_ON_START=1: go to RUN, t=0, selects 0, ENX_Int=1. The pending ENX/Output_Valid are cancelled.
  - RESTART_ON_START=0: no state change; Start_Drop=1 next cycle.
- Input_Valid together with Stall in IDLE: start is accepted; the stall applies from the first RUN cycle.
- With default parameters and no stall (t=0 is the first cycle after accept): selects reach 27 at t=27; ENX_Int bit27 at t=51; ENX at t=64; Output_Valid at t=65.
- Illegal parameters (PIPE_LAT<1, NUM_EN<1, 2**SEL_W<NUM_TAPS) must fail elaboration.

Decomposition:
- Shared package mac_ctrl_pkg: the state enumeration (IDLE, RUN, DRAIN, FIRE, DONE), a clog2 constant function, and the derived-timing constant functions (T_END, T_FIRE).
- One sub-module, onehot_walker: ports clk, GlobalReset, clear, shift_en; parameter NUM_EN. It holds the one-hot register, saturates at the MSB and reloads bit0 on clear.
- FSM, step counter and select saturation stay in mac_seq_ctrl.

Test Plan:
- Reset mid-pass at t=30 -> all outputs return to reset values asynchronously; the next start runs a clean, full pass.
- Defaults, single Input_Valid pulse, Stall=0 -> selects 0..27 then hold at 27; ENX_Int bit0 through t=24, bit27 from t=51; ENX only at t=64; Output_Valid only at t=65; Busy high for t=0..65.
- Stall held 5 cycles at t=10 and 3 cycles at t=60 -> ENX at t=72 and Output_Valid at t=73, counted from accept; outputs frozen during each stall.
- RESTART_ON_START=1, second Input_Valid at t=40 -> selects 0 and ENX_Int=1 next cycle; no ENX is issued before the new pass's t=64. With RESTART_ON_START=0 -> Start_Drop pulses once and the original timing is unchanged.
- Input_Valid in the Output_Valid cycle -> next cycle RUN with t=0; two complete passes with no idle cycle between them.
- NUM_TAPS=8, NUM_EN=4, EN_START=2, PIPE_LAT=1, SEL_W=3 -> selects saturate at 7 (t=7); ENX_Int bit3 at t=5; ENX at t=8; Output_Valid at t=9.

Source files
------------

// File: rtl/mac_ctrl_pkg.sv
// Shared types and derived-timing helpers for the neuron MAC sequencer.
package mac_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_FIRE  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Last step of the tap sweep or the lane walk, whichever ends later.
  function automatic int unsigned t_end(input int unsigned num_taps,
                                        input int unsigned num_en,
                                        input int unsigned en_start);
    int unsigned walk;
    walk = en_start + num_en - 1;
    return (num_taps - 1 > walk) ? num_taps - 1 : walk;
  endfunction

  function automatic int unsigned t_fire(input int unsigned num_taps,
                                         input int unsigned num_en,
                                         input int unsigned en_start,
                                         input int unsigned pipe_lat);
    return t_end(num_taps, num_en, en_start) + pipe_lat;
  endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Start/stall handshake and select/enable bus between the loader and the MAC array.
interface mac_seq_ctrl_if #(
  parameter int unsigned SEL_W  = 5,
  parameter int unsigned NUM_EN = 28
);
  logic              Input_Valid;
  logic              Stall;
  logic [SEL_W-1:0]  WeightX_Select;
  logic [SEL_W-1:0]  PixelX_Select;
  logic [NUM_EN-1:0] ENX_Int;
  logic              ENX;
  logic              Output_Valid;
  logic              Busy;
  logic              Start_Drop;

  modport master (
    output Input_Valid, Stall,
    input  WeightX_Select, PixelX_Select, ENX_Int, ENX, Output_Valid, Busy, Start_Drop
  );

  modport slave (
    input  Input_Valid, Stall,
    output WeightX_Select, PixelX_Select, ENX_Int, ENX, Output_Valid, Busy, Start_Drop
  );
endinterface

// File: rtl/mac_seq_ctrl_onehot_walker.sv
// One-hot lane-enable register: shifts toward the MSB, saturates there, reloads bit0 on clear.
module onehot_walker #(
  parameter int unsigned NUM_EN = 28
) (
  input  logic              clk,
  input  logic              GlobalReset,
  input  logic              clear,
  input  logic              shift_en,
  output logic [NUM_EN-1:0] lanes
);

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset)                         lanes <= NUM_EN'(1);
    else if (clear)                          lanes <= NUM_EN'(1);
    else if (shift_en && !lanes[NUM_EN-1])   lanes <= lanes << 1;
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Pass sequencer for the MAC datapath: steps tap selects, walks lane enables,
// then fires ENX and Output_Valid after the pipeline drain.
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int unsigned NUM_TAPS         = 28,
  parameter int unsigned SEL_W            = 5,
  parameter int unsigned NUM_EN           = 28,
  parameter int unsigned EN_START         = 24,
  parameter int unsigned PIPE_LAT         = 13,
  parameter int unsigned RESTART_ON_START = 1
) (
  input logic            clk,
  input logic            GlobalReset,
  mac_seq_ctrl_if.slave  bus
);

  localparam int unsigned T_END_C  = t_end(NUM_TAPS, NUM_EN, EN_START);
  localparam int unsigned T_FIRE_C = t_fire(NUM_TAPS, NUM_EN, EN_START, PIPE_LAT);
  localparam int unsigned CNT_W    = clog2(T_FIRE_C + 2);
  localparam int unsigned SEL_MAX  = NUM_TAPS - 1;

  if (PIPE_LAT < 1) begin : g_bad_pipe_lat
    $error("mac_seq_ctrl: PIPE_LAT must be at least 1");
  end
  if (NUM_EN < 1) begin : g_bad_num_en
    $error("mac_seq_ctrl: NUM_EN must be at least 1");
  end
  if ((64'(1) << SEL_W) < 64'(NUM_TAPS)) begin : g_bad_sel_w
    $error("mac_seq_ctrl: SEL_W too narrow for NUM_TAPS");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d, t_inc;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             enx_q, enx_d;
  logic             ov_q, ov_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;
  logic             clear_c, shift_c;
  logic             restart_c;

  assign t_inc     = t_q + CNT_W'(1);
  assign restart_c = bus.Input_Valid && (RESTART_ON_START != 0);

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      sel_q   <= '0;
      enx_q   <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      sel_q   <= sel_d;
      enx_q   <= enx_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state and next-output logic; "start" always wins over stall.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    sel_d   = sel_q;
    enx_d   = 1'b0;
    ov_d    = 1'b0;
    busy_d  = busy_q;
    drop_d  = 1'b0;
    clear_c = 1'b0;
    shift_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.Input_Valid) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          clear_c = 1'b1;
        end
      end
      S_RUN, S_DRAIN: begin
        if (restart_c) begin
          state_d = S_RUN;
          t_d     = '0;
          sel_d   = '0;
          clear_c = 1'b1;
        end else begin
          drop_d = bus.Input_Valid;
          if (!bus.Stall) begin
            t_d     = t_inc;
            sel_d   = (t_inc >= CNT_W'(SEL_MAX)) ? SEL_W'(SEL_MAX) : SEL_W'(t_inc);
            shift_c = (t_q >= CNT_W'(EN_START));
            if (t_inc == CNT_W'(T_FIRE_C)) begin
              state_d = S_FIRE;
              enx_d   = 1'b1;
            end else if (t_inc > CNT_W'(T_END_C)) begin
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_FIRE: begin
        if (restart_c) begin
          state_d = S_RUN;
          t_d     = '0;
          sel_d   = '0;
          clear_c = 1'b1;
        end else begin
          drop_d  = bus.Input_Valid;
          state_d = S_DONE;
          t_d     = t_inc;
          ov_d    = 1'b1;
        end
      end
      S_DONE: begin
        t_d     = '0;
        sel_d   = '0;
        clear_c = 1'b1;
        if (bus.Input_Valid) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        t_d     = '0;
        sel_d   = '0;
        busy_d  = 1'b0;
        clear_c = 1'b1;
      end
    endcase
  end

  onehot_walker #(.NUM_EN(NUM_EN)) u_walker (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .clear       (clear_c),
    .shift_en    (shift_c),
    .lanes       (bus.ENX_Int)
  );

  assign bus.WeightX_Select = sel_q;
  assign bus.PixelX_Select  = sel_q;
  assign bus.ENX            = enx_q;
  assign bus.Output_Valid   = ov_q;
  assign bus.Busy           = busy_q;
  assign bus.Start_Drop     = drop_q;

endmodule
